x161_chain_sequencer: RTL and testbench

//  Controller for a cascade of N 74161-style 4-bit counters forming a programmable timer.

---
 rtl/x161_seq_pkg.sv | 9 +
 rtl/x161_prescaler.sv | 21 ++
 rtl/x161_chain_sequencer.sv | 103 ++++++++++
 tb/tb_x161_chain_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/x161_seq_pkg.sv
// x161_seq_pkg: shared types and helpers for the 74161 chain sequencer.
// Contents: state_t FSM encoding, STAGE_W (bits per counter stage), all_ones(w) mask helper.
package x161_seq_pkg;
    localparam int STAGE_W = 4;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    function automatic logic [63:0] all_ones(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction
endpackage

// File: rtl/x161_prescaler.sv
// x161_prescaler: tick divider for the chain sequencer, built only with X161_PRESCALE_EN.
// Ports: CP clock, CR async active-low reset, clr restarts the divide period,
//        div selects a tick every div+1 cycles, tick is the combinational enable pulse.
`ifdef X161_PRESCALE_EN
module x161_prescaler #(
    parameter int PRESC_W = 4
) (
    input  logic               CP,
    input  logic               CR,
    input  logic               clr,
    input  logic [PRESC_W-1:0] div,
    output logic               tick
);
    logic [PRESC_W-1:0] cnt_q, cnt_d;
    assign tick = (cnt_q == div);
    always_comb cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
    always_ff @(posedge CP or negedge CR)
        if (!CR) cnt_q <= '0;
        else cnt_q <= cnt_d;
endmodule
`endif

// File: rtl/x161_chain_sequencer.sv
// x161_chain_sequencer: one-shot/periodic timer controller for a cascade of 74161 counters.
// Optional feature macro: X161_PRESCALE_EN (RUN actions only on prescaler ticks).
// Ports: CP clock; CR async active-low reset; start/stop/pause/periodic control;
//        preset start value; presc_div prescaler select; q_in chain Q (stage 0 in LSBs);
//        cnt_cr_n/cnt_pe_n/cnt_cep/cnt_cet/cnt_d chain controls; busy/done/wrap status.
module x161_chain_sequencer
    import x161_seq_pkg::*;
#(
    parameter int N_STAGE = 2,
    parameter int PRESC_W = 4
) (
    input  logic                         CP,
    input  logic                         CR,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         pause,
    input  logic                         periodic,
    input  logic [STAGE_W*N_STAGE-1:0]   preset,
    input  logic [PRESC_W-1:0]           presc_div,
    input  logic [STAGE_W*N_STAGE-1:0]   q_in,
    output logic                         cnt_cr_n,
    output logic                         cnt_pe_n,
    output logic                         cnt_cep,
    output logic                         cnt_cet,
    output logic [STAGE_W*N_STAGE-1:0]   cnt_d,
    output logic                         busy,
    output logic                         done,
    output logic                         wrap
);
    localparam int W = STAGE_W * N_STAGE;
    localparam logic [W-1:0] MAX = W'(all_ones(W));

    state_t         state_q, state_d;
    logic [W-1:0]   preset_q, preset_d;
    logic           periodic_q, periodic_d;
    logic           busy_q, busy_d, done_q, done_d, wrap_q, wrap_d, cr_n_q, cr_n_d;
    logic           tick, max, act, accept;

    assign accept = (state_q == IDLE) && start && !stop;

`ifdef X161_PRESCALE_EN
    x161_prescaler #(.PRESC_W(PRESC_W)) u_presc (
        .CP   (CP),
        .CR   (CR),
        .clr  (accept),
        .div  (presc_div),
        .tick (tick)
    );
`else
    logic unused_presc_div;
    assign unused_presc_div = ^presc_div;
    assign tick = 1'b1;
`endif

    // act: a RUN cycle where the chain is allowed to move (tick present, not paused)
    assign max      = (q_in == MAX);
    assign act      = (state_q == RUN) && tick && !pause;
    assign cnt_pe_n = !((state_q == LOAD) || (act && max && periodic_q));
    assign cnt_cep  = act && !max;
    assign cnt_cet  = cnt_cep;
    assign cnt_d    = preset_q;
    assign cnt_cr_n = cr_n_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign wrap     = wrap_q;

    always_comb begin
        state_d    = state_q;
        preset_d   = preset_q;
        periodic_d = periodic_q;
        if (accept) begin
            state_d    = LOAD;
            preset_d   = preset;
            periodic_d = periodic;
        end else if (stop && state_q != IDLE) state_d = IDLE;
        else if (state_q == LOAD) state_d = RUN;
        else if (state_q == DONE) state_d = IDLE;
        else if (act && max && !periodic_q) state_d = DONE;
        busy_d = (state_d == LOAD) || (state_d == RUN);
        done_d = (state_q == DONE) && !stop;
        wrap_d = act && max && periodic_q && !stop;
        cr_n_d = !(stop && state_q != IDLE);
    end

    always_ff @(posedge CP or negedge CR)
        if (!CR) begin
            state_q    <= IDLE;
            preset_q   <= '0;
            periodic_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wrap_q     <= 1'b0;
            cr_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            preset_q   <= preset_d;
            periodic_q <= periodic_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wrap_q     <= wrap_d;
            cr_n_q     <= cr_n_d;
        end
endmodule

// File: tb/tb_x161_chain_sequencer.sv
// tb_x161_chain_sequencer: scoreboard bench driving the sequencer against a two-stage 74161 chain model.
module tb_x161_chain_sequencer;
    logic       CP = 1'b0, CR = 1'b1;
    logic       start = 1'b0, stop = 1'b0, pause = 1'b0, periodic = 1'b0;
    logic [7:0] preset = '0, q = '0;
    logic [3:0] presc_div = 4'd2;
    logic       cnt_cr_n, cnt_pe_n, cnt_cep, cnt_cet, busy, done, wrap;
    logic [7:0] cnt_d;
    int         cyc = 0, t0 = 0, n_tests = 0, n_fail = 0;

    typedef struct {int cyc; string sig; string name; logic [31:0] val;} exp_t;
    exp_t sb[$];

    x161_chain_sequencer #(.N_STAGE(2), .PRESC_W(4)) dut (
        .CP(CP), .CR(CR), .start(start), .stop(stop), .pause(pause), .periodic(periodic),
        .preset(preset), .presc_div(presc_div), .q_in(q),
        .cnt_cr_n(cnt_cr_n), .cnt_pe_n(cnt_pe_n), .cnt_cep(cnt_cep), .cnt_cet(cnt_cet),
        .cnt_d(cnt_d), .busy(busy), .done(done), .wrap(wrap)
    );

    always #5 CP = ~CP;
    always @(posedge CP) cyc <= cyc + 1;

    // 74161 pair: async clear, sync load, stage 1 enabled through stage 0 terminal count
    always @(posedge CP or negedge cnt_cr_n)
        if (!cnt_cr_n) q <= '0;
        else if (!cnt_pe_n) q <= cnt_d;
        else if (cnt_cep && cnt_cet) begin
            q[3:0] <= q[3:0] + 4'd1;
            if (q[3:0] == 4'hF) q[7:4] <= q[7:4] + 4'd1;
        end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int rel, input string sig, input logic [31:0] val);
        sb.push_back('{t0 + rel, sig, $sformatf("%s@c%0d", sig, rel), val});
    endtask

    function automatic logic [31:0] obs(input string sig);
        case (sig)
            "q":    return {24'd0, q};
            "d":    return {24'd0, cnt_d};
            "pe_n": return {31'd0, cnt_pe_n};
            "cep":  return {31'd0, cnt_cep};
            "busy": return {31'd0, busy};
            "done": return {31'd0, done};
            "wrap": return {31'd0, wrap};
            "cr_n": return {31'd0, cnt_cr_n};
            default: return 'x;
        endcase
    endfunction

    always @(negedge CP)
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            check(e.name, obs(e.sig), e.val);
        end

    task automatic step(input int n);
        repeat (n) @(posedge CP);
        #1;
    endtask

    task automatic drain(input int budget);
        while (sb.size() > 0 && budget > 0) begin
            @(negedge CP);
            #1;
            budget--;
        end
        if (sb.size() > 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        step(2);
    endtask

    task automatic launch(input logic [7:0] p, input logic per);
        preset = p;
        periodic = per;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_wrap"}, wrap, 0);
        check({tag, "_cr_n"}, cnt_cr_n, 1);
        check({tag, "_pe_n"}, cnt_pe_n, 1);
        check({tag, "_cep"}, cnt_cep, 0);
        check({tag, "_cet"}, cnt_cet, 0);
        check({tag, "_d"}, cnt_d, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        #1 CR = 1'b0;
        #1 reset_checks("rst");
        step(1);
        CR = 1'b1;
        step(2);

        // one-shot F0, with a start/preset/periodic change while busy
        t0 = cyc;
        push(1, "pe_n", 0);
        push(1, "busy", 1);
        for (int k = 0; k < 16; k++) begin
            push(2 + k, "q", 8'hF0 + k);
            push(2 + k, "done", 0);
            if (k == 0) push(2, "cep", 1);
            if (k == 4) push(6, "d", 8'hF0);
        end
        push(17, "cep", 0);
        push(18, "busy", 0);
        push(18, "done", 0);
        push(19, "done", 1);
        push(19, "busy", 0);
        push(20, "done", 0);
        launch(8'hF0, 1'b0);
        step(4);
        start = 1'b1;
        preset = 8'h00;
        periodic = 1'b1;
        step(1);
        start = 1'b0;
        drain(60);

        // periodic FC, stopped at FF
        t0 = cyc;
        for (int k = 0; k < 16; k++) begin
            push(2 + k, "q", 8'hFC + (k % 4));
            if (k >= 4) push(2 + k, "wrap", (k % 4 == 0) ? 1 : 0);
            push(2 + k, "done", 0);
        end
        push(18, "busy", 0);
        push(18, "cr_n", 0);
        push(18, "wrap", 0);
        push(18, "q", 0);
        push(18, "done", 0);
        push(19, "cr_n", 1);
        push(19, "q", 0);
        push(19, "done", 0);
        launch(8'hFC, 1'b1);
        step(16);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        drain(60);

        // pause for 3 cycles at F5
        t0 = cyc;
        for (int k = 0; k < 6; k++) push(2 + k, "q", 8'hF0 + k);
        for (int k = 8; k <= 10; k++) push(k, "q", 8'hF5);
        push(11, "q", 8'hF6);
        push(20, "q", 8'hFF);
        push(21, "done", 0);
        push(22, "done", 1);
        launch(8'hF0, 1'b0);
        step(6);
        pause = 1'b1;
        step(3);
        pause = 1'b0;
        drain(60);

        // stop together with start at F8
        t0 = cyc;
        push(10, "q", 8'hF8);
        push(11, "busy", 0);
        push(11, "cr_n", 0);
        push(11, "q", 0);
        push(11, "done", 0);
        push(12, "cr_n", 1);
        push(12, "pe_n", 1);
        push(12, "busy", 0);
        push(12, "done", 0);
        push(13, "busy", 0);
        push(13, "done", 0);
        launch(8'hF0, 1'b0);
        step(9);
        stop = 1'b1;
        start = 1'b1;
        step(1);
        stop = 1'b0;
        start = 1'b0;
        drain(60);

        // CR pulsed low mid-run
        launch(8'hF0, 1'b0);
        step(4);
        CR = 1'b0;
        #1 reset_checks("midrst");
        step(1);
        CR = 1'b1;
        t0 = cyc;
        for (int k = 1; k <= 20; k++) begin
            push(k, "done", 0);
            push(k, "busy", 0);
        end
        drain(40);

        // preset all-ones, one-shot
        t0 = cyc;
        push(2, "q", 8'hFF);
        push(2, "cep", 0);
        push(3, "done", 0);
        push(3, "busy", 0);
        push(4, "done", 1);
        launch(8'hFF, 1'b0);
        drain(20);

        // preset all-ones, periodic: wrap every tick
        t0 = cyc;
        push(2, "q", 8'hFF);
        push(2, "pe_n", 0);
        push(3, "wrap", 1);
        push(3, "q", 8'hFF);
        push(4, "wrap", 1);
        push(5, "wrap", 1);
        push(6, "wrap", 0);
        push(6, "cr_n", 0);
        launch(8'hFF, 1'b1);
        step(4);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        drain(20);

`ifdef X161_PRESCALE_EN
        // prescaled one-shot: divide by 3
        presc_div = 4'd2;
        t0 = cyc;
        push(2, "q", 8'hFE);
        push(2, "cep", 0);
        push(3, "q", 8'hFE);
        push(4, "q", 8'hFF);
        push(6, "q", 8'hFF);
        push(7, "done", 0);
        push(8, "done", 1);
        launch(8'hFE, 1'b0);
        drain(30);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
